image_line_streamer: RTL
========================

# image_line_streamer

Line-credited pixel source that reads a grayscale frame from a synchronous-read frame memory and drives it as an 8-bit valid/ready stream into the convolution top's slave input. A fixed number of lines is preloaded. After that, one further line is released for each line-buffer-free interrupt returned by the convolution pixel controller, so the line buffers never overflow. Sits between the frame memory and the convolution top's slave port; its interrupt input is wired to the convolution top's interrupt output.

## Interface
- IMG_WIDTH, 512, pixels per line (≥2)
- IMG_HEIGHT, 512, lines per frame (≥1)
- PRELOAD_LINES, 4, line credits granted at start
- ADDR_W, 18, frame memory address width (≥ clog2(IMG_WIDTH*IMG_HEIGHT))
- i_clk  in  1  single clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  single-cycle start pulse; ignored while o_busy
- o_busy  out  1  high from the cycle after an accepted start until o_done
- o_done  out  1  one-cycle pulse after the final pixel handshake
- o_mem_rd  out  1  read strobe
- o_mem_addr  out  ADDR_W  linear pixel address, row*IMG_WIDTH+col
- i_mem_rdata  in  8  read data, valid exactly 1 cycle after o_mem_rd
- o_data_valid  out  1  stream valid
- o_data  out  8  pixel
- o_data_last  out  1  high on the last pixel of each line
- i_data_ready  in  1  stream ready
- i_intr  in  1  line-consumed interrupt; each rising edge adds one credit

## Operation
- Reset values: o_busy=0, o_done=0, o_mem_rd=0, o_mem_addr=0, o_data_valid=0, o_data=0, o_data_last=0, credits=0, state IDLE, FIFO empty, intr edge register=0.
- FSM states and transitions:
  - IDLE: on i_start, clear counters, set credits=min(PRELOAD_LINES, IMG_HEIGHT), go to FETCH.
  - FETCH: issue reads while credits>0 and FIFO has room. On the issue of the last column, decrement the credit. After the last pixel of the frame is issued, go to DRAIN. With credits=0, no reads are issued; the state stays FETCH (stall).
  - DRAIN: wait until the FIFO is empty and no read is in flight, then go to DONE.
  - DONE: pulse o_done for one cycle, return to IDLE.
- Issue rule: read when (FIFO occupancy + in-flight − pop this cycle) < FIFO depth (4). The block sustains 1 pixel/cycle with i_data_ready held high.
- Counters: col 0..IMG_WIDTH−1, row 0..IMG_HEIGHT−1. Address increments by 1 per issue, with no wrap within a frame. last = (col==IMG_WIDTH−1) tagged at issue.
- Credit counter is 8 bits and saturates at 255.
  - Intr edge and line-end decrement in the same cycle: net zero.
  - Intr edges in IDLE, DRAIN and DONE are ignored.
  - Credits beyond the remaining lines are harmless.
- Stream rules:
  - o_data, o_data_last and o_data_valid are stable while o_data_valid && !i_data_ready.
  - Valid never drops without a handshake.
  - Pixels leave in address order with no duplication or loss.
- Reset mid-frame: all state is cleared asynchronously and o_data_valid drops immediately. In-flight memory data is discarded. A fresh i_start restarts at address 0.

## Timing
- i_start sampled high at edge N:
  - o_busy high and first o_mem_rd (addr 0) in cycle N+1.
  - First o_data_valid in cycle N+3.
- Read-to-output latency: 2 cycles (memory 1, FIFO register 1).
- i_intr rising edge detected at edge M: credit usable for an issue in cycle M+1.
- o_done asserts the cycle after the final handshake. o_busy falls in the same cycle o_done is high.

## Structure
- Shared package conv_pkg:
  - PIXEL_W=8.
  - FSM state encoding (IDLE, FETCH, DRAIN, DONE).
  - STREAM_FIFO_DEPTH=4.
  - Default image dimensions shared with the pixel controller.
- One sub-module: stream_fifo, a synchronous 4-deep FIFO of 9 bits (pixel+last) with registered outputs, count output, and async active-high reset.

## Test plan
- 4×3 image, PRELOAD=4, ready high, memory[i]=i:
  - 12 beats with values 0..11.
  - last on beats 3, 7, 11.
  - o_done 1 cycle after beat 11.
- 4×6 image, PRELOAD=4:
  - 16 beats, then no o_mem_rd for 50 cycles.
  - One i_intr edge → exactly beats 16..19.
  - A second edge → 20..23, then o_done.
- Ready toggled pseudo-randomly on a 16×4 frame: 64 beats in order 0..63, data held stable during stalls.
- i_intr edge in the same cycle as the last-column issue with credits=1: credits stay 1 and the next line streams without stall.
- Reset asserted mid-line 1 of 8×4: valid drops at once. Restart → first beat is 0, full frame correct.
- i_start pulsed while busy: no effect; exactly one o_done.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution pixel path: pixel width, stream FIFO
// depth, default frame size and the streamer FSM state encoding.
package conv_pkg;

  localparam int PIXEL_W            = 8;
  localparam int STREAM_FIFO_DEPTH  = 4;
  localparam int DEFAULT_IMG_WIDTH  = 512;
  localparam int DEFAULT_IMG_HEIGHT = 512;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic               last;
    logic [PIXEL_W-1:0] pixel;
  } stream_beat_t;

endpackage

// File: rtl/stream_fifo.sv
// Shift-register FIFO; slot 0 is the head, so the stream outputs are driven
// straight from flops.
module stream_fifo
  import conv_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  stream_beat_t i_push_data,
  input  logic         i_pop,
  output stream_beat_t o_head,
  output logic         o_valid,
  output logic [2:0]   o_count
);

  localparam int CNT_W = $clog2(STREAM_FIFO_DEPTH) + 1;

  stream_beat_t [STREAM_FIFO_DEPTH-1:0] slot_q, slot_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] base;
  logic             pop_ok;
  logic             push_ok;

  always_comb begin
    pop_ok  = i_pop && (count_q != '0);
    // occupancy after this cycle's pop decides where a push lands
    base    = count_q - CNT_W'(pop_ok);
    push_ok = i_push && (base < CNT_W'(STREAM_FIFO_DEPTH));
    slot_d  = slot_q;
    if (pop_ok) begin
      for (int i = 0; i < STREAM_FIFO_DEPTH - 1; i++) begin
        slot_d[i] = slot_q[i+1];
      end
    end
    if (push_ok) begin
      slot_d[base[CNT_W-2:0]] = i_push_data;
    end
    count_d = base + CNT_W'(push_ok);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  assign o_head  = slot_q[0];
  assign o_valid = (count_q != '0);
  assign o_count = count_q;

endmodule

// File: rtl/image_line_streamer.sv
// Line-credited pixel source: reads a frame from synchronous memory and streams
// it out, releasing one more line per line-buffer-free interrupt.
//
//   state | meaning
//   IDLE  | waiting for i_start
//   FETCH | issuing reads while credits and FIFO room allow
//   DRAIN | all reads issued, waiting for FIFO and read pipe to empty
//   DONE  | one-cycle o_done, back to IDLE
module image_line_streamer
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH     = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT    = DEFAULT_IMG_HEIGHT,
  parameter int PRELOAD_LINES = 4,
  parameter int ADDR_W        = 18
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_mem_rd,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic [PIXEL_W-1:0] i_mem_rdata,
  output logic               o_data_valid,
  output logic [PIXEL_W-1:0] o_data,
  output logic               o_data_last,
  input  logic               i_data_ready,
  input  logic               i_intr
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam int PRE_MIN = (PRELOAD_LINES < IMG_HEIGHT) ? PRELOAD_LINES : IMG_HEIGHT;
  localparam logic [7:0] INIT_CREDITS = 8'((PRE_MIN > 255) ? 255 : PRE_MIN);

  logic [1:0]        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        credits_q, credits_d;
  logic              intr_q;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;

  stream_beat_t      head;
  stream_beat_t      push_beat;
  logic              fifo_valid;
  logic [2:0]        fifo_count;
  logic              pop;
  logic              room;
  logic              issue;
  logic              at_line_end;
  logic              intr_rise;

  always_comb begin
    pop         = fifo_valid && i_data_ready;
    // a read issued now lands after the in-flight one, so reserve its slot
    room        = (({1'b0, fifo_count} + {3'b000, inflight_q}) - {3'b000, pop})
                  < 4'(STREAM_FIFO_DEPTH);
    at_line_end = (col_q == LAST_COL);
    intr_rise   = i_intr && !intr_q;
    issue       = (state_q == ST_FETCH) && (credits_q != 8'd0) && room;

    state_d         = state_q;
    col_d           = col_q;
    row_d           = row_q;
    addr_d          = addr_q;
    credits_d       = credits_q;
    inflight_d      = issue;
    inflight_last_d = issue && at_line_end;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_FETCH;
          col_d     = '0;
          row_d     = '0;
          addr_d    = '0;
          credits_d = INIT_CREDITS;
        end
      end
      ST_FETCH: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          if (at_line_end) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
            if (row_q == LAST_ROW) begin
              state_d = ST_DRAIN;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
        if (intr_rise && !(issue && at_line_end)) begin
          credits_d = (credits_q == 8'hFF) ? credits_q : credits_q + 8'd1;
        end else if (!intr_rise && issue && at_line_end) begin
          credits_d = credits_q - 8'd1;
        end
      end
      ST_DRAIN: begin
        // leave as the last beat handshakes so o_done lands the cycle after
        if (!inflight_q && ((fifo_count - 3'(pop)) == 3'd0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      col_q           <= '0;
      row_q           <= '0;
      addr_q          <= '0;
      credits_q       <= '0;
      intr_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      col_q           <= col_d;
      row_q           <= row_d;
      addr_q          <= addr_d;
      credits_q       <= credits_d;
      intr_q          <= i_intr;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign push_beat = '{last: inflight_last_q, pixel: i_mem_rdata};

  stream_fifo u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (inflight_q),
    .i_push_data (push_beat),
    .i_pop       (pop),
    .o_head      (head),
    .o_valid     (fifo_valid),
    .o_count     (fifo_count)
  );

  assign o_busy       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign o_done       = (state_q == ST_DONE);
  assign o_mem_rd     = issue;
  assign o_mem_addr   = addr_q;
  assign o_data_valid = fifo_valid;
  assign o_data       = head.pixel;
  assign o_data_last  = head.last;

endmodule
